// File: rtl/receptor_pkg.sv
// Shared constants, state encodings and byte helpers for the serial weight receiver.
// The state codes double as the db_estado debug values.
package receptor_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NOVE = 8'h39;
  localparam logic [7:0] ASCII_TERM = 8'h23;
  localparam int         N_DIGITOS  = 6;

  typedef enum logic [3:0] {
    ESPERA     = 4'd0,
    DIGITO     = 4'd1,
    TERMINADOR = 4'd2,
    FIM        = 4'd3,
    ERRO       = 4'd4,
    RESYNC     = 4'd5
  } estado_montador_t;

  typedef enum logic [2:0] {
    RX_IDLE     = 3'd0,
    RX_START    = 3'd1,
    RX_DATA     = 3'd2,
    RX_PARIDADE = 3'd3,
    RX_STOP     = 3'd4
  } estado_rx_t;

  function automatic logic e_digito(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NOVE);
  endfunction

  // Even parity: the parity bit equals the XOR of the data bits.
  function automatic logic paridade_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_serial.sv
// UART receiver: 2-FF synchronizer, RX FSM and baud/bit counters. 8N1 by default;
// defining RECEPTOR_PARIDADE_EN adds an even-parity bit (8E1).
module uart_rx_serial
  import receptor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic       rx_pronto,
  output logic       rx_erro,
  output logic [7:0] rx_dado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] MEIO_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FIM_BIT  = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_r;
  logic          linha_s;
  estado_rx_t    estado_r, estado_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [2:0]    bit_r, bit_nxt_s;
  logic [7:0]    shift_r, shift_nxt_s;
  logic          armado_r, armado_nxt_s;
  logic          pronto_r, pronto_nxt_s;
  logic          erro_r, erro_nxt_s;
  logic [7:0]    dado_r, dado_nxt_s;
  logic          par_err_s;

`ifdef RECEPTOR_PARIDADE_EN
  logic par_err_r, par_err_nxt_s;
  assign par_err_s = par_err_r;
`else
  assign par_err_s = 1'b0;
`endif

  assign linha_s = sync_r[1];

  // Line synchronizer; resets to idle-high so no false start appears.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_r <= 2'b11;
    else        sync_r <= {sync_r[0], entrada_serial};
  end

  // RX next-state and datapath.
  always_comb begin
    estado_nxt_s = estado_r;
    cnt_nxt_s    = cnt_r;
    bit_nxt_s    = bit_r;
    shift_nxt_s  = shift_r;
    armado_nxt_s = armado_r;
    pronto_nxt_s = 1'b0;
    erro_nxt_s   = 1'b0;
    dado_nxt_s   = dado_r;
`ifdef RECEPTOR_PARIDADE_EN
    par_err_nxt_s = par_err_r;
`endif
    case (estado_r)
      RX_IDLE: begin
        cnt_nxt_s = '0;
        // A start is only armed once the line has been seen high again.
        if (!armado_r) begin
          armado_nxt_s = linha_s;
        end else if (!linha_s) begin
          estado_nxt_s = RX_START;
        end else begin
          estado_nxt_s = RX_IDLE;
        end
      end
      RX_START: begin
        if (cnt_r == MEIO_BIT) begin
          cnt_nxt_s    = '0;
          bit_nxt_s    = 3'd0;
          estado_nxt_s = linha_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt_r == FIM_BIT) begin
          cnt_nxt_s   = '0;
          shift_nxt_s = {linha_s, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef RECEPTOR_PARIDADE_EN
            estado_nxt_s = RX_PARIDADE;
`else
            estado_nxt_s = RX_STOP;
`endif
          end else begin
            bit_nxt_s = bit_r + 3'd1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
`ifdef RECEPTOR_PARIDADE_EN
      RX_PARIDADE: begin
        if (cnt_r == FIM_BIT) begin
          cnt_nxt_s     = '0;
          par_err_nxt_s = (linha_s != paridade_par(shift_r));
          estado_nxt_s  = RX_STOP;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
`endif
      RX_STOP: begin
        if (cnt_r == FIM_BIT) begin
          cnt_nxt_s    = '0;
          estado_nxt_s = RX_IDLE;
          armado_nxt_s = 1'b0;
          if (linha_s && !par_err_s) begin
            pronto_nxt_s = 1'b1;
            dado_nxt_s   = shift_r;
          end else begin
            erro_nxt_s = 1'b1;
          end
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: estado_nxt_s = RX_IDLE;
    endcase
  end

  // RX state, counters and registered output pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r <= RX_IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      shift_r  <= 8'h00;
      armado_r <= 1'b0;
      pronto_r <= 1'b0;
      erro_r   <= 1'b0;
      dado_r   <= 8'h00;
`ifdef RECEPTOR_PARIDADE_EN
      par_err_r <= 1'b0;
`endif
    end else begin
      estado_r <= estado_nxt_s;
      cnt_r    <= cnt_nxt_s;
      bit_r    <= bit_nxt_s;
      shift_r  <= shift_nxt_s;
      armado_r <= armado_nxt_s;
      pronto_r <= pronto_nxt_s;
      erro_r   <= erro_nxt_s;
      dado_r   <= dado_nxt_s;
`ifdef RECEPTOR_PARIDADE_EN
      par_err_r <= par_err_nxt_s;
`endif
    end
  end

  assign rx_pronto = pronto_r;
  assign rx_erro   = erro_r;
  assign rx_dado   = dado_r;

endmodule

// File: rtl/receptor_pesos.sv
// Serial weight-frame receiver: six ASCII digits plus '#', committed to valor_reg.
// RECEPTOR_PARIDADE_EN selects 8E1 framing in the UART receiver.
module receptor_pesos
  import receptor_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [47:0] valor_reg,
  output logic        fim_recepcao,
  output logic        erro_recepcao,
  output logic [7:0]  dado_recebido,
  output logic [3:0]  db_estado
);

  logic             rx_pronto_s, rx_erro_s;
  logic [7:0]       rx_dado_s;
  estado_montador_t estado_r, estado_nxt_s;
  logic [47:0]      staging_r, staging_nxt_s;
  logic [2:0]       idx_r, idx_nxt_s;
  logic             volta_espera_r, volta_espera_nxt_s;
  logic [47:0]      valor_r;
  logic             fim_r, erro_r;
  logic [7:0]       dado_r;

  uart_rx_serial #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .rx_pronto      (rx_pronto_s),
    .rx_erro        (rx_erro_s),
    .rx_dado        (rx_dado_s)
  );

  // Frame assembler next-state. A framing/parity error leaves no offending byte
  // to resynchronise on, so it returns straight to ESPERA like a stray '#'.
  always_comb begin
    estado_nxt_s       = estado_r;
    staging_nxt_s      = staging_r;
    idx_nxt_s          = idx_r;
    volta_espera_nxt_s = volta_espera_r;
    case (estado_r)
      ESPERA, DIGITO: begin
        if (rx_erro_s) begin
          estado_nxt_s       = ERRO;
          volta_espera_nxt_s = 1'b1;
        end else if (rx_pronto_s) begin
          if (e_digito(rx_dado_s)) begin
            staging_nxt_s = {staging_r[39:0], rx_dado_s};
            idx_nxt_s     = idx_r + 3'd1;
            estado_nxt_s  = (idx_r == 3'(N_DIGITOS - 1)) ? TERMINADOR : DIGITO;
          end else begin
            estado_nxt_s       = ERRO;
            volta_espera_nxt_s = (rx_dado_s == ASCII_TERM);
          end
        end else begin
          estado_nxt_s = estado_r;
        end
      end
      TERMINADOR: begin
        if (rx_erro_s) begin
          estado_nxt_s       = ERRO;
          volta_espera_nxt_s = 1'b1;
        end else if (rx_pronto_s) begin
          if (rx_dado_s == ASCII_TERM) begin
            estado_nxt_s = FIM;
          end else begin
            estado_nxt_s       = ERRO;
            volta_espera_nxt_s = 1'b0;
          end
        end else begin
          estado_nxt_s = TERMINADOR;
        end
      end
      FIM: begin
        estado_nxt_s  = ESPERA;
        staging_nxt_s = 48'h0;
        idx_nxt_s     = 3'd0;
      end
      ERRO: begin
        estado_nxt_s  = volta_espera_r ? ESPERA : RESYNC;
        staging_nxt_s = 48'h0;
        idx_nxt_s     = 3'd0;
      end
      RESYNC: begin
        if (rx_erro_s) begin
          estado_nxt_s       = ERRO;
          volta_espera_nxt_s = 1'b1;
        end else if (rx_pronto_s && (rx_dado_s == ASCII_TERM)) begin
          estado_nxt_s = ESPERA;
        end else begin
          estado_nxt_s = RESYNC;
        end
      end
      default: begin
        estado_nxt_s  = ESPERA;
        staging_nxt_s = 48'h0;
        idx_nxt_s     = 3'd0;
      end
    endcase
  end

  // Assembler state plus registered outputs; valor_reg only moves on entry to FIM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_r       <= ESPERA;
      staging_r      <= 48'h0;
      idx_r          <= 3'd0;
      volta_espera_r <= 1'b0;
      valor_r        <= 48'h0;
      fim_r          <= 1'b0;
      erro_r         <= 1'b0;
      dado_r         <= 8'h00;
    end else begin
      estado_r       <= estado_nxt_s;
      staging_r      <= staging_nxt_s;
      idx_r          <= idx_nxt_s;
      volta_espera_r <= volta_espera_nxt_s;
      fim_r          <= (estado_nxt_s == FIM);
      erro_r         <= (estado_nxt_s == ERRO);
      if (estado_nxt_s == FIM) valor_r <= staging_r;
      else                     valor_r <= valor_r;
      if (rx_pronto_s) dado_r <= rx_dado_s;
      else             dado_r <= dado_r;
    end
  end

  assign valor_reg     = valor_r;
  assign fim_recepcao  = fim_r;
  assign erro_recepcao = erro_r;
  assign dado_recebido = dado_r;
  assign db_estado     = estado_r;

endmodule

// File: tb/tb_receptor_pesos.sv
// Directed bench for receptor_pesos with CLKS_PER_BIT=16 and ideal UART frames.
module tb_receptor_pesos;

  localparam int CPB = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        entrada_serial = 1'b1;
  logic [47:0] valor_reg;
  logic        fim_recepcao, erro_recepcao;
  logic [7:0]  dado_recebido;
  logic [3:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int fim_cnt = 0;
  int erro_cnt = 0;
  int leak_cnt = 0;
  logic [47:0] valor_prev = 48'h0;
`ifdef RECEPTOR_PARIDADE_EN
  bit par_flip = 1'b0;
`endif

  receptor_pesos #(.CLKS_PER_BIT(CPB)) dut (
    .clock          (clock),
    .reset          (reset),
    .entrada_serial (entrada_serial),
    .valor_reg      (valor_reg),
    .fim_recepcao   (fim_recepcao),
    .erro_recepcao  (erro_recepcao),
    .dado_recebido  (dado_recebido),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters and a watch for valor_reg moving without fim_recepcao.
  always @(negedge clock) begin
    if (reset) begin
      if (fim_recepcao) fim_cnt++;
      if (erro_recepcao) erro_cnt++;
      if ((valor_reg !== valor_prev) && !fim_recepcao) leak_cnt++;
    end
    valor_prev = valor_reg;
  end

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    entrada_serial = 1'b0;
    repeat (CPB) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      entrada_serial = b[i];
      repeat (CPB) @(posedge clock);
    end
`ifdef RECEPTOR_PARIDADE_EN
    entrada_serial = par_flip ? ~(^b) : (^b);
    repeat (CPB) @(posedge clock);
`endif
    entrada_serial = stop_bit;
    repeat (CPB) @(posedge clock);
    entrada_serial = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_counts();
    fim_cnt  = 0;
    erro_cnt = 0;
  endtask

  initial begin
    // Reset state
    idle(5);
    chk("reset_valor", valor_reg, 48'h0);
    chk("reset_dado", {40'h0, dado_recebido}, 48'h0);
    chk("reset_pulses", {46'h0, fim_recepcao, erro_recepcao}, 48'h0);
    chk("reset_estado", {44'h0, db_estado}, 48'h0);
    reset = 1'b1;
    idle(10);

    // 1: valid frame "123045#"
    clear_counts();
    send_str("123045");
    idle(2);
    chk("t1_terminador", {44'h0, db_estado}, 48'd2);
    chk("t1_no_early_commit", valor_reg, 48'h0);
    send_str("#");
    idle(20);
    chk("t1_valor", valor_reg, 48'h313233303435);
    chk("t1_fim_cnt", 48'(fim_cnt), 48'd1);
    chk("t1_erro_cnt", 48'(erro_cnt), 48'd0);
    chk("t1_dado", {40'h0, dado_recebido}, 48'h23);
    chk("t1_espera", {44'h0, db_estado}, 48'd0);

    // 2: bad digit then resync on '#'
    clear_counts();
    send_str("12A");
    idle(2);
    chk("t2_erro_cnt", 48'(erro_cnt), 48'd1);
    chk("t2_resync", {44'h0, db_estado}, 48'd5);
    send_str("045");
    idle(2);
    chk("t2_still_resync", {44'h0, db_estado}, 48'd5);
    send_str("#");
    idle(20);
    chk("t2_espera", {44'h0, db_estado}, 48'd0);
    chk("t2_valor_kept", valor_reg, 48'h313233303435);
    chk("t2_no_fim", 48'(fim_cnt), 48'd0);
    chk("t2_erro_once", 48'(erro_cnt), 48'd1);

    // 3: short low glitch is not a byte
    clear_counts();
    entrada_serial = 1'b0;
    repeat (4) @(posedge clock);
    entrada_serial = 1'b1;
    idle(40);
    chk("t3_dado_same", {40'h0, dado_recebido}, 48'h23);
    chk("t3_no_erro", 48'(erro_cnt), 48'd0);
    chk("t3_espera", {44'h0, db_estado}, 48'd0);
    send_str("999999#");
    idle(20);
    chk("t3_valor", valor_reg, 48'h393939393939);
    chk("t3_fim_cnt", 48'(fim_cnt), 48'd1);

    // 4: framing error then a good frame
    clear_counts();
    send_byte(8'h35, 1'b0);
    idle(20);
    chk("t4_erro_cnt", 48'(erro_cnt), 48'd1);
    chk("t4_dado_discarded", {40'h0, dado_recebido}, 48'h23);
    chk("t4_valor_kept", valor_reg, 48'h393939393939);
    send_str("000000#");
    idle(20);
    chk("t4_valor", valor_reg, 48'h303030303030);
    chk("t4_fim_cnt", 48'(fim_cnt), 48'd1);
    chk("t4_erro_total", 48'(erro_cnt), 48'd1);

    // 5: reset in the middle of the 4th digit
    send_str("987");
    entrada_serial = 1'b0;
    repeat (CPB) @(posedge clock);
    entrada_serial = 1'b0;
    repeat (3 * CPB) @(posedge clock);
    reset = 1'b0;
    #1;
    chk("t5_valor_rst", valor_reg, 48'h0);
    chk("t5_dado_rst", {40'h0, dado_recebido}, 48'h0);
    chk("t5_pulses_rst", {46'h0, fim_recepcao, erro_recepcao}, 48'h0);
    chk("t5_estado_rst", {44'h0, db_estado}, 48'd0);
    entrada_serial = 1'b1;
    idle(5);
    reset = 1'b1;
    idle(20);
    clear_counts();
    send_str("987654#");
    idle(20);
    chk("t5_valor", valor_reg, 48'h393837363534);
    chk("t5_fim_cnt", 48'(fim_cnt), 48'd1);
    chk("t5_erro_cnt", 48'(erro_cnt), 48'd0);

`ifdef RECEPTOR_PARIDADE_EN
    // 6: wrong parity then correct-parity frame
    clear_counts();
    par_flip = 1'b1;
    send_str("1");
    par_flip = 1'b0;
    idle(20);
    chk("t6_erro_cnt", 48'(erro_cnt), 48'd1);
    send_str("111111#");
    idle(20);
    chk("t6_valor", valor_reg, 48'h313131313131);
    chk("t6_fim_cnt", 48'(fim_cnt), 48'd1);
`endif

    chk("valor_leak", 48'(leak_cnt), 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
